ds_engine: RTL and testbench



---
 rtl/ds_pkg.sv | 26 ++
 rtl/ds_engine_if.sv | 45 ++++
 rtl/ds_addr_gen.sv | 45 ++++
 rtl/ds_engine.sv | 124 ++++++++++++
 tb/tb_ds_engine.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ds_pkg.sv
// ============================================================================
// Module      : ds_pkg
// Description : Shared widths and FSM state encoding for the 2x2 downsampler.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package ds_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int SUM_W  = 10;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        RD2  = 3'd3,
        RD3  = 3'd4,
        WR   = 3'd5,
        FIN  = 3'd6
    } ds_state_t;

endpackage

`default_nettype wire

// File: rtl/ds_engine_if.sv
// ============================================================================
// Module      : ds_engine_if
// Description : Control handshake and data-memory port between the engine and
//               the memory/controller side.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ds_engine_if;
    import ds_pkg::*;

    logic              start;
    logic              busy;
    logic              done;
    logic              finish_signal;
    logic [ADDR_W-1:0] address;
    logic              Mem_Write;
    logic [DATA_W-1:0] memory_in;
    logic [DATA_W-1:0] memory_out;

    modport master (
        input  start,
        input  memory_out,
        output busy,
        output done,
        output finish_signal,
        output address,
        output Mem_Write,
        output memory_in
    );

    modport slave (
        output start,
        output memory_out,
        input  busy,
        input  done,
        input  finish_signal,
        input  address,
        input  Mem_Write,
        input  memory_in
    );

endinterface

`default_nettype wire

// File: rtl/ds_addr_gen.sv
// ============================================================================
// Module      : ds_addr_gen
// Description : Combinational memory address decode from block counters and
//               FSM state (2x2 read taps, output write address).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ds_addr_gen
    import ds_pkg::*;
#(
    parameter int                IMG_W    = 128,
    parameter logic [ADDR_W-1:0] OUT_BASE = 16'h8000
) (
    input  ds_state_t         i_state,
    input  logic [ADDR_W-1:0] i_i,
    input  logic [ADDR_W-1:0] i_j,
    output logic [ADDR_W-1:0] o_address
);

    localparam logic [ADDR_W-1:0] c_img_w  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] c_half_w = ADDR_W'(IMG_W / 2);

    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] w_out;

    // Top-left pixel of block (i,j) is at row 2i, column 2j of the input.
    assign w_base = ((i_i << 1) * c_img_w) + (i_j << 1);
    assign w_out  = OUT_BASE + (i_i * c_half_w) + i_j;

    always_comb begin
        o_address = '0;
        case (i_state)
            RD0:     o_address = w_base;
            RD1:     o_address = w_base + ADDR_W'(1);
            RD2:     o_address = w_base + c_img_w;
            RD3:     o_address = w_base + c_img_w + ADDR_W'(1);
            WR:      o_address = w_out;
            default: o_address = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ds_engine.sv
// ============================================================================
// Module      : ds_engine
// Description : 2x2 block-average downsampler driving the data memory port.
//               Define DS_ROUND_EN for round-half-up averaging (else truncate).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ds_engine
    import ds_pkg::*;
#(
    parameter int                IMG_W    = 128,
    parameter int                IMG_H    = 128,
    parameter logic [ADDR_W-1:0] OUT_BASE = 16'h8000
) (
    input  logic          clk,
    input  logic          reset,
    ds_engine_if.master   bus
);

    if ((IMG_W < 2) || (IMG_W % 2 != 0) || (IMG_H < 2) || (IMG_H % 2 != 0)) begin : g_chk_dims
        $error("ds_engine: IMG_W and IMG_H must be even and at least 2");
    end
    if (IMG_W * IMG_H > int'(OUT_BASE)) begin : g_chk_overlap
        $error("ds_engine: input image overlaps the output region");
    end
    if (int'(OUT_BASE) + (IMG_W * IMG_H) / 4 > 65536) begin : g_chk_range
        $error("ds_engine: output image exceeds the 64 KiB address space");
    end

    localparam logic [ADDR_W-1:0] c_last_i = ADDR_W'(IMG_H / 2 - 1);
    localparam logic [ADDR_W-1:0] c_last_j = ADDR_W'(IMG_W / 2 - 1);

    ds_state_t          r_state;
    ds_state_t          w_next;
    logic [ADDR_W-1:0]  r_i;
    logic [ADDR_W-1:0]  r_j;
    logic [SUM_W-1:0]   r_sum;
    logic [SUM_W-1:0]   w_pix;
    logic [SUM_W-1:0]   w_sum_adj;
    logic [DATA_W-1:0]  w_avg;
    logic               w_last;
    logic [ADDR_W-1:0]  w_address;

    assign w_pix  = {{(SUM_W - DATA_W){1'b0}}, bus.memory_out};
    assign w_last = (r_i == c_last_i) && (r_j == c_last_j);

`ifdef DS_ROUND_EN
    assign w_sum_adj = r_sum + SUM_W'(2);
`else
    assign w_sum_adj = r_sum;
`endif
    assign w_avg = w_sum_adj[SUM_W-1:2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.start ? RD0 : IDLE;
            RD0:     w_next = RD1;
            RD1:     w_next = RD2;
            RD2:     w_next = RD3;
            RD3:     w_next = WR;
            WR:      w_next = w_last ? FIN : RD0;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_i   <= '0;
            r_j   <= '0;
            r_sum <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_i <= '0;
                        r_j <= '0;
                    end
                end
                RD0:           r_sum <= w_pix;
                RD1, RD2, RD3: r_sum <= r_sum + w_pix;
                WR: begin
                    if (r_j == c_last_j) begin
                        r_j <= '0;
                        r_i <= r_i + ADDR_W'(1);
                    end else begin
                        r_j <= r_j + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    ds_addr_gen #(
        .IMG_W    (IMG_W),
        .OUT_BASE (OUT_BASE)
    ) u_addr_gen (
        .i_state   (r_state),
        .i_i       (r_i),
        .i_j       (r_j),
        .o_address (w_address)
    );

    assign bus.address       = w_address;
    assign bus.Mem_Write     = (r_state == WR);
    assign bus.memory_in     = (r_state == WR) ? w_avg : '0;
    assign bus.busy          = (r_state != IDLE);
    assign bus.done          = (r_state == FIN);
    assign bus.finish_signal = (r_state == FIN);

endmodule

`default_nettype wire

// File: tb/tb_ds_engine.sv
// ============================================================================
// Module      : tb_ds_engine
// Description : Self-checking bench for ds_engine: 4x4 and 8x2 images against
//               a block-average reference model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ds_engine;

`ifdef DS_ROUND_EN
    localparam int RND = 2;
`else
    localparam int RND = 0;
`endif

    bit          clk;
    bit          rst;
    bit          start;
    bit          sel;
    bit          pl_we;
    bit          pl_sel;
    logic [7:0]  pl_addr;
    logic [7:0]  pl_data;
    logic [7:0]  mem_a [0:255];
    logic [7:0]  mem_b [0:255];

    int          n_vec;
    int          n_err;
    int          img   [0:15];
    int          expv  [0:3];

    ds_engine_if bus_a ();
    ds_engine_if bus_b ();

    assign bus_a.start      = start & ~sel;
    assign bus_b.start      = start & sel;
    assign bus_a.memory_out = mem_a[bus_a.address[7:0]];
    assign bus_b.memory_out = mem_b[bus_b.address[7:0]];

    logic        m_we, m_busy, m_done, m_fin;
    logic [15:0] m_addr;
    logic [7:0]  m_din;

    assign m_we   = sel ? bus_b.Mem_Write     : bus_a.Mem_Write;
    assign m_busy = sel ? bus_b.busy          : bus_a.busy;
    assign m_done = sel ? bus_b.done          : bus_a.done;
    assign m_fin  = sel ? bus_b.finish_signal : bus_a.finish_signal;
    assign m_addr = sel ? bus_b.address       : bus_a.address;
    assign m_din  = sel ? bus_b.memory_in     : bus_a.memory_in;

    ds_engine #(.IMG_W(4), .IMG_H(4), .OUT_BASE(16'h0010)) u_dut_a (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_a)
    );

    ds_engine #(.IMG_W(8), .IMG_H(2), .OUT_BASE(16'h0020)) u_dut_b (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus_a.Mem_Write) mem_a[bus_a.address[7:0]] <= bus_a.memory_in;
        if (bus_b.Mem_Write) mem_b[bus_b.address[7:0]] <= bus_b.memory_in;
        if (pl_we) begin
            if (pl_sel) mem_b[pl_addr] <= pl_data;
            else        mem_a[pl_addr] <= pl_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] peek(input bit s, input int a);
        logic [7:0] v;
        v = s ? mem_b[a[7:0]] : mem_a[a[7:0]];
        return {24'h0, v};
    endfunction

    task automatic poke(input bit s, input int a, input int d);
        @(negedge clk);
        pl_we   = 1'b1;
        pl_sel  = s;
        pl_addr = a[7:0];
        pl_data = d[7:0];
        @(posedge clk);
        #1;
        pl_we = 1'b0;
    endtask

    task automatic load(input bit s);
        int base;
        base = s ? 32'h20 : 32'h10;
        for (int k = 0; k < 16; k++) poke(s, k, img[k]);
        for (int k = 0; k < 4; k++)  poke(s, base + k, 8'hA5);
    endtask

    task automatic rand_img();
        for (int k = 0; k < 16; k++) img[k] = int'($urandom_range(0, 255));
    endtask

    // Reference: average of each 2x2 block, output in raster order.
    task automatic model(input bit s);
        int w, ow, bi, bj, b, sum;
        w  = s ? 8 : 4;
        ow = w / 2;
        for (int k = 0; k < 4; k++) begin
            bi  = k / ow;
            bj  = k % ow;
            b   = 2 * bi * w + 2 * bj;
            sum = img[b] + img[b + 1] + img[b + w] + img[b + w + 1];
            expv[k] = (sum + RND) / 4;
        end
    endtask

    task automatic run(input bit s, input bit mid_start, input int rst_cyc);
        int base, wcnt, fin;
        base = s ? 32'h20 : 32'h10;
        wcnt = 0;
        fin  = 0;
        sel  = s;
        model(s);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (mid_start) start = (c == 7) || (c == 13);
            if (c == rst_cyc) begin
                #2;
                rst = 1'b1;
            end
            @(negedge clk);
            if (c == 1) begin
                chk("rd0_busy", m_busy, 1);
                chk("rd0_addr", m_addr, 0);
            end
            if (m_we) begin
                if (wcnt < 4) begin
                    chk("wr_cycle", c, 5 * (wcnt + 1));
                    chk("wr_addr", m_addr, base + wcnt);
                    chk("wr_data", m_din, expv[wcnt]);
                end else begin
                    chk("extra_write", wcnt, 3);
                end
                wcnt++;
            end
            if (rst_cyc != 0 && c >= rst_cyc) begin
                chk("rst_we", m_we, 0);
                chk("rst_busy", m_busy, 0);
                chk("rst_addr", m_addr, 0);
                chk("rst_fin", m_fin, 0);
            end
            if (m_fin) begin
                chk("done_with_fin", m_done, 1);
                fin = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        if (rst_cyc != 0) begin
            rst = 1'b0;
            chk("rst_n_writes", wcnt, 1);
            chk("rst_no_fin", fin, 0);
            @(negedge clk);
            chk("rst_idle_busy", m_busy, 0);
            chk("rst_mem0", peek(s, base), expv[0]);
            for (int k = 1; k < 4; k++) chk("rst_mem_kept", peek(s, base + k), 8'hA5);
        end else begin
            chk("fin_cycle", fin, 21);
            chk("n_writes", wcnt, 4);
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("post_busy", m_busy, 0);
            chk("post_fin", m_fin, 0);
            chk("post_done", m_done, 0);
            for (int k = 0; k < 4; k++) chk("mem_out", peek(s, base + k), expv[k]);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        start = 1'b0;
        sel   = 1'b0;
        pl_we = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy0", bus_a.busy, 0);
        chk("rst_done0", bus_a.done, 0);
        chk("rst_fin0", bus_a.finish_signal, 0);
        chk("rst_addr0", bus_a.address, 0);
        chk("rst_we0", bus_a.Mem_Write, 0);
        chk("rst_din0", bus_a.memory_in, 0);
        rst = 1'b0;

        // Uniform image of 100.
        for (int k = 0; k < 16; k++) img[k] = 100;
        load(0);
        run(0, 0, 0);
        for (int k = 0; k < 4; k++) chk("uniform100", peek(0, 16 + k), 100);

        // Top-left block 1,1,2,2 with random remainder.
        rand_img();
        img[0] = 1; img[1] = 1; img[4] = 2; img[5] = 2;
        load(0);
        run(0, 0, 0);
        chk("tl_block", peek(0, 16), (RND != 0) ? 2 : 1);

        // Saturated image.
        for (int k = 0; k < 16; k++) img[k] = 255;
        load(0);
        run(0, 0, 0);
        for (int k = 0; k < 4; k++) chk("all255", peek(0, 16 + k), 255);

        // Same random image with and without a mid-run start pulse.
        rand_img();
        load(0);
        run(0, 0, 0);
        load(0);
        run(0, 1, 0);

        // Reset during the second pixel's RD2, then a clean run.
        rand_img();
        load(0);
        run(0, 0, 8);
        rand_img();
        load(0);
        run(0, 0, 0);

        // 8x2 image on the second instance.
        repeat (3) begin
            rand_img();
            load(1);
            run(1, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
